// File: rtl/mul_seq_core.sv
// Sequential shift-add multiplier: one add/shift step per clock for WIDTH steps, then a done pulse.
// Optional build macro MUL_SIGNED_EN selects radix-2 Booth (two's complement) instead of unsigned shift-add.
module mul_seq_core #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   m_reg;
   logic [2*WIDTH:0]   acc;
   logic [2*WIDTH:0]   acc_next;
   logic               last_step;
   logic               load;

   assign last_step = (count == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Start is only honoured from IDLE or DONE; a start during CALC is dropped.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = CALC;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef MUL_SIGNED_EN
   logic             q;
   logic [WIDTH:0]   upper;
   logic [WIDTH:0]   m_ext;

   // Booth pair {A[0], q}: 01 adds M, 10 subtracts M; the shift is arithmetic.
   always_comb begin
      m_ext = {m_reg[WIDTH-1], m_reg};
      upper = acc[2*WIDTH:WIDTH];
      case ({acc[0], q})
         2'b01:   upper = acc[2*WIDTH:WIDTH] + m_ext;
         2'b10:   upper = acc[2*WIDTH:WIDTH] - m_ext;
         default: upper = acc[2*WIDTH:WIDTH];
      endcase
      acc_next = {upper[WIDTH], upper, acc[WIDTH-1:1]};
   end
`else
   logic [WIDTH:0]   upper;

   always_comb begin
      upper = acc[2*WIDTH:WIDTH];
      if (acc[0]) begin
         upper = acc[2*WIDTH:WIDTH] + {1'b0, m_reg};
      end
      acc_next = {1'b0, upper, acc[WIDTH-1:1]};
   end
`endif

   // Product is written only on the final step so partial sums never leak out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         m_reg   <= '0;
         acc     <= '0;
         product <= '0;
`ifdef MUL_SIGNED_EN
         q       <= 1'b0;
`endif
      end else if (load) begin
         count   <= '0;
         m_reg   <= multiplicand;
         acc     <= {{(WIDTH+1){1'b0}}, multiplier};
`ifdef MUL_SIGNED_EN
         q       <= 1'b0;
`endif
      end else if (state == CALC) begin
         count <= count + CW'(1);
         acc   <= acc_next;
`ifdef MUL_SIGNED_EN
         q     <= acc[0];
`endif
         if (last_step) begin
            product <= acc_next[2*WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_mul_seq_core.sv
// Self-checking bench for mul_seq_core against an arithmetic reference model.
// Honours MUL_SIGNED_EN the same way the design does.
module tb_mul_seq_core;

   localparam int WIDTH = 32;

   logic                 clk;
   logic                 rst_n;
   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   int checks = 0;
   int errors = 0;

   mul_seq_core #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_SIGNED_EN
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
`else
      return {32'b0, a} * {32'b0, b};
`endif
   endfunction

   // Accepts a start at the next rising edge, then counts edges until done.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_cnt);
      @(negedge clk);
      start        = 1'b1;
      multiplicand = a;
      multiplier   = b;
      @(posedge clk);
      #1;
      start        = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
      busy_cnt     = busy ? 1 : 0;
      edges        = 0;
      while (!done && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
         if (busy) busy_cnt++;
      end
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
         errors++;
         $display("[TB] FAIL reset_state: busy=%b done=%b product=%h, required 0/0/0", busy, done, product);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int edges;
      int busy_cnt;
      run_mul(32'd3, 32'd5, edges, busy_cnt);
      checks++;
      if (edges !== WIDTH) begin
         errors++;
         $display("[TB] FAIL basic_latency: done after %0d edges past start edge, required %0d", edges, WIDTH);
      end
      checks++;
      if (busy_cnt !== WIDTH) begin
         errors++;
         $display("[TB] FAIL basic_busy: busy high %0d cycles, required %0d", busy_cnt, WIDTH);
      end
      checks++;
      if (product !== 64'h000000000000000F) begin
         errors++;
         $display("[TB] FAIL basic_product: got %h, required %h", product, 64'hF);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_done_pulse: done=%b busy=%b one edge later, required 0/0", done, busy);
      end
   endtask

   task automatic test_corners();
      int edges;
      int busy_cnt;
      logic [63:0] fixed;
      run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, edges, busy_cnt);
`ifdef MUL_SIGNED_EN
      fixed = 64'h0000000000000001;
`else
      fixed = 64'hFFFFFFFE00000001;
`endif
      checks++;
      if (product !== fixed) begin
         errors++;
         $display("[TB] FAIL all_ones: got %h, required %h", product, fixed);
      end
      run_mul(32'h80000000, 32'h00000002, edges, busy_cnt);
`ifdef MUL_SIGNED_EN
      fixed = 64'hFFFFFFFF00000000;
`else
      fixed = 64'h0000000100000000;
`endif
      checks++;
      if (product !== fixed) begin
         errors++;
         $display("[TB] FAIL min_times_two: got %h, required %h", product, fixed);
      end
      run_mul(32'h00000000, 32'hDEADBEEF, edges, busy_cnt);
      checks++;
      if (product !== 64'd0) begin
         errors++;
         $display("[TB] FAIL zero_operand: got %h, required 0", product);
      end
   endtask

   task automatic test_random();
      int edges;
      int busy_cnt;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] expected;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: a = 32'h80000000;
            1: b = 32'h7FFFFFFF;
            2: a = 32'd1;
            default: ;
         endcase
         expected = ref_mul(a, b);
         run_mul(a, b, edges, busy_cnt);
         checks++;
         if (edges !== WIDTH || product !== expected) begin
            errors++;
            $display("[TB] FAIL random_%0d: %h*%h got %h after %0d edges, required %h after %0d",
                     i, a, b, product, edges, expected, WIDTH);
         end
      end
   endtask

   task automatic test_start_ignored();
      int edges;
      int pulses;
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 32'd7;
      multiplier   = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 32'd2;
      multiplier   = 32'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges = 10;
      while (!done && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
      checks++;
      if (edges !== WIDTH || product !== 64'd63) begin
         errors++;
         $display("[TB] FAIL start_ignored: product %0d at edge %0d, required 63 at edge %0d", product, edges, WIDTH);
      end
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("[TB] FAIL start_ignored_pulses: %0d extra done pulses, required 0", pulses);
      end
   endtask

   task automatic test_reset_abort();
      int edges;
      int busy_cnt;
      int pulses;
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 32'd6;
      multiplier   = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: busy=%b done=%b product=%h, required 0/0/0", busy, done, product);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("[TB] FAIL abort_no_done: %0d busy/done cycles after abort, required 0", pulses);
      end
      run_mul(32'd6, 32'd7, edges, busy_cnt);
      checks++;
      if (product !== 64'd42 || edges !== WIDTH) begin
         errors++;
         $display("[TB] FAIL after_abort: got %0d after %0d edges, required 42 after %0d", product, edges, WIDTH);
      end
   endtask

   task automatic test_back_to_back();
      int edges;
      int busy_cnt;
      logic [63:0] first;
      first = ref_mul(32'd11, 32'd13);
      run_mul(32'd11, 32'd13, edges, busy_cnt);
      start        = 1'b1;
      multiplicand = 32'd4;
      multiplier   = 32'd4;
      checks++;
      if (done !== 1'b1 || product !== first) begin
         errors++;
         $display("[TB] FAIL b2b_first: done=%b product=%h, required 1 and %h", done, product, first);
      end
      @(posedge clk);
      #1;
      start        = 1'b0;
      multiplicand = $urandom;
      multiplier   = $urandom;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || product !== first) begin
         errors++;
         $display("[TB] FAIL b2b_restart: busy=%b done=%b product=%h, required 1/0/%h", busy, done, product, first);
      end
      edges = 1;
      while (!done && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
      checks++;
      if (edges !== WIDTH + 1 || product !== 64'd16) begin
         errors++;
         $display("[TB] FAIL b2b_second: product %0d after %0d edges, required 16 after %0d", product, edges, WIDTH + 1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_random();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
